carregador_programa: RTL and testbench

Program loader that sits directly upstream of the 512×32 instruction/data memory and fills it from an external word stream (disk or host link) before the processor runs. It accepts a header, a payload and a checksum over a valid/ready handshake, writes the payload into consecutive memory locations, then reads every written word back and re-checks the checksum. It reports completion or error to the control unit and drives the memory's `dado`/`endereco`/`write` inputs while it is active.

---
 rtl/carregador_programa.sv | 157 +++++++++++++++
 tb/tb_carregador_programa.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_programa.sv
// Program loader: receives header/payload/checksum over valid/ready, writes the payload into
// memory, then reads it back and re-verifies the checksum before reporting done or error.
module carregador_programa #(
  parameter int unsigned PROF   = 512,
  parameter logic [5:0]  MAGICO = 6'b111111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_dado,
  input  logic        in_valido,
  output logic        in_pronto,
  output logic [31:0] mem_dado,
  output logic [9:0]  mem_endereco,
  output logic        mem_write,
  input  logic [31:0] mem_saida,
  output logic        ocupado,
  output logic        concluido,
  output logic        erro,
  output logic [9:0]  palavras
);

  typedef enum logic [2:0] {
    StOcioso, StCabecalho, StDados, StSoma, StVerifica, StFim, StErro
  } estado_t;

  localparam logic [10:0] PROF_11 = 11'(PROF);

  estado_t     estado_q, estado_d;
  logic [9:0]  base_q, base_d;
  logic [9:0]  len_q, len_d;
  logic [9:0]  palavras_q, palavras_d;
  logic [31:0] soma_rx_q, soma_rx_d;
  logic [31:0] soma_rd_q, soma_rd_d;
  logic [31:0] mem_dado_q, mem_dado_d;
  logic [9:0]  mem_end_q, mem_end_d;
  logic        mem_write_q, mem_write_d;
  logic [9:0]  rd_idx_q, rd_idx_d;  // verify addresses issued so far
  logic [9:0]  smp_q, smp_d;        // verify words sampled so far

  logic        transf;
  logic [10:0] fim_11;
  logic [31:0] soma_rd_nova;

  assign transf       = in_valido & in_pronto;
  assign fim_11       = {1'b0, in_dado[25:16]} + {1'b0, in_dado[9:0]};
  assign soma_rd_nova = soma_rd_q + mem_saida;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= StOcioso;
      base_q      <= '0;
      len_q       <= '0;
      palavras_q  <= '0;
      soma_rx_q   <= '0;
      soma_rd_q   <= '0;
      mem_dado_q  <= '0;
      mem_end_q   <= '0;
      mem_write_q <= 1'b0;
      rd_idx_q    <= '0;
      smp_q       <= '0;
    end else begin
      estado_q    <= estado_d;
      base_q      <= base_d;
      len_q       <= len_d;
      palavras_q  <= palavras_d;
      soma_rx_q   <= soma_rx_d;
      soma_rd_q   <= soma_rd_d;
      mem_dado_q  <= mem_dado_d;
      mem_end_q   <= mem_end_d;
      mem_write_q <= mem_write_d;
      rd_idx_q    <= rd_idx_d;
      smp_q       <= smp_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    base_d      = base_q;
    len_d       = len_q;
    palavras_d  = palavras_q;
    soma_rx_d   = soma_rx_q;
    soma_rd_d   = soma_rd_q;
    mem_dado_d  = mem_dado_q;
    mem_end_d   = mem_end_q;
    mem_write_d = 1'b0;
    rd_idx_d    = rd_idx_q;
    smp_d       = smp_q;

    case (estado_q)
      StOcioso, StFim, StErro: begin
        if (start) begin
          estado_d   = StCabecalho;
          palavras_d = '0;
          soma_rx_d  = '0;
          soma_rd_d  = '0;
          rd_idx_d   = '0;
          smp_d      = '0;
        end
      end
      StCabecalho: begin
        if (transf) begin
          base_d = in_dado[25:16];
          len_d  = in_dado[9:0];
          if (in_dado[31:26] != MAGICO)  estado_d = StErro;
          else if (fim_11 > PROF_11)     estado_d = StErro;
          else if (in_dado[9:0] == '0)   estado_d = StSoma;
          else                           estado_d = StDados;
        end
      end
      StDados: begin
        if (transf) begin
          mem_end_d   = base_q + palavras_q;
          mem_dado_d  = in_dado;
          mem_write_d = 1'b1;
          soma_rx_d   = soma_rx_q + in_dado;
          palavras_d  = palavras_q + 10'd1;
          if (palavras_q + 10'd1 == len_q) estado_d = StSoma;
        end
      end
      StSoma: begin
        if (transf) begin
          if (in_dado != soma_rx_q) estado_d = StErro;
          else if (len_q == '0)     estado_d = StFim;
          else                      estado_d = StVerifica;
        end
      end
      StVerifica: begin
        if (rd_idx_q != len_q) begin
          mem_end_d = base_q + rd_idx_q;
          rd_idx_d  = rd_idx_q + 10'd1;
        end
        // memory output reflects the address presented during the previous cycle
        if (rd_idx_q != '0) begin
          soma_rd_d = soma_rd_nova;
          smp_d     = smp_q + 10'd1;
          if (smp_q + 10'd1 == len_q) begin
            estado_d = (soma_rd_nova == soma_rx_q) ? StFim : StErro;
          end
        end
      end
      default: estado_d = StOcioso;
    endcase
  end

  assign in_pronto    = (estado_q == StCabecalho) || (estado_q == StDados) ||
                        (estado_q == StSoma);
  assign ocupado      = !((estado_q == StOcioso) || (estado_q == StFim) ||
                          (estado_q == StErro));
  assign concluido    = (estado_q == StFim);
  assign erro         = (estado_q == StErro);
  assign palavras     = palavras_q;
  assign mem_dado     = mem_dado_q;
  assign mem_endereco = mem_end_q;
  assign mem_write    = mem_write_q;

endmodule

// File: tb/tb_carregador_programa.sv
// Bench for carregador_programa: memory model plus write scoreboard, directed load scenarios.
module tb_carregador_programa;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] in_dado;
  logic        in_valido;
  logic        in_pronto;
  logic [31:0] mem_dado;
  logic [9:0]  mem_endereco;
  logic        mem_write;
  logic [31:0] mem_saida;
  logic        ocupado;
  logic        concluido;
  logic        erro;
  logic [9:0]  palavras;

  carregador_programa #(.PROF(512), .MAGICO(6'b111111)) dut (
    .clock(clock), .reset(reset), .start(start), .in_dado(in_dado), .in_valido(in_valido),
    .in_pronto(in_pronto), .mem_dado(mem_dado), .mem_endereco(mem_endereco),
    .mem_write(mem_write), .mem_saida(mem_saida), .ocupado(ocupado), .concluido(concluido),
    .erro(erro), .palavras(palavras)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_writes = 0;
  int          cyc = 0;
  int          t0 = 0;
  logic [31:0] mem [512];
  logic [31:0] pl [16];
  bit          corrupt = 1'b0;
  logic [9:0]  corrupt_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory: writes on rising edge, read port updates on falling edge
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_write) mem[mem_endereco[8:0]] <= mem_dado;
  end

  always @(negedge clock)
    mem_saida <= mem[mem_endereco[8:0]] ^
                 ((corrupt && mem_endereco == corrupt_addr) ? 32'h1 : 32'h0);

  always @(negedge clock) begin
    if (mem_write === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {22'b0, mem_endereco}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {22'b0, mem_endereco}, {22'b0, e.a});
        chk("wr_data", mem_dado, e.d);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_pronto"}, {31'b0, in_pronto}, 0);
    chk({tag, "_mem_write"}, {31'b0, mem_write}, 0);
    chk({tag, "_mem_dado"}, mem_dado, 0);
    chk({tag, "_mem_end"}, {22'b0, mem_endereco}, 0);
    chk({tag, "_ocupado"}, {31'b0, ocupado}, 0);
    chk({tag, "_concluido"}, {31'b0, concluido}, 0);
    chk({tag, "_erro"}, {31'b0, erro}, 0);
    chk({tag, "_palavras"}, {22'b0, palavras}, 0);
  endtask

  // All steps start and end at posedge+1
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    int k;
    if (gaps) begin
      in_valido = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
    in_dado = w;
    in_valido = 1'b1;
    k = 0;
    while (!in_pronto && k < 50) begin @(posedge clock); #1; k++; end
    if (!in_pronto) chk("pronto_timeout", {31'b0, in_pronto}, 1);
    @(posedge clock); #1;
  endtask

  task automatic run_load(input logic [9:0] b, input logic [9:0] n, input logic [31:0] cxor,
                          input bit gaps, input int start_at);
    logic [31:0] sum;
    sum = 0;
    pulse_start();
    send_word({6'b111111, b, 6'b0, n}, 1'b0);
    for (int i = 0; i < int'(n); i++) begin
      if (i == start_at) begin
        in_valido = 1'b0;
        pulse_start();
        chk("midstart_ocupado", {31'b0, ocupado}, 1);
        chk("midstart_pronto", {31'b0, in_pronto}, 1);
        chk("midstart_palavras", {22'b0, palavras}, i);
      end
      exp_q.push_back('{a: b + 10'(i), d: pl[i]});
      sum = sum + pl[i];
      send_word(pl[i], gaps);
    end
    send_word(sum ^ cxor, gaps);
    in_valido = 1'b0;
  endtask

  task automatic wait_done(output int dt);
    int k;
    k = 0;
    while (!(concluido || erro) && k < 300) begin @(posedge clock); #1; k++; end
    dt = cyc - t0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dt;
    int wr0;
    logic [9:0] end0;

    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    reset = 1'b0; start = 1'b0; in_valido = 1'b0; in_dado = '0;
    #2;
    check_all_zero("reset");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Nominal: B=15, N=6, back-to-back, with wrapping checksum
    for (int i = 0; i < 6; i++) pl[i] = 32'hFFFF_FFF0 + 32'(i * 7);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    t0 = cyc;
    chk("start_ocupado", {31'b0, ocupado}, 1);
    chk("start_pronto", {31'b0, in_pronto}, 1);
    start = 1'b0;
    send_word({6'b111111, 10'd15, 6'b0, 10'd6}, 1'b0);
    begin
      logic [31:0] s;
      s = 0;
      for (int i = 0; i < 6; i++) begin
        exp_q.push_back('{a: 10'd15 + 10'(i), d: pl[i]});
        s = s + pl[i];
        send_word(pl[i], 1'b0);
      end
      send_word(s, 1'b0);
      in_valido = 1'b0;
    end
    wait_done(dt);
    chk("nom_latency", dt, 15);
    chk("nom_concluido", {31'b0, concluido}, 1);
    chk("nom_erro", {31'b0, erro}, 0);
    chk("nom_ocupado", {31'b0, ocupado}, 0);
    chk("nom_palavras", {22'b0, palavras}, 6);
    for (int i = 0; i < 6; i++) chk("nom_mem", mem[15 + i], pl[i]);

    // Bad magic: error one cycle after header, nothing written
    wr0 = n_writes;
    pulse_start();
    send_word({6'b000001, 10'd3, 6'b0, 10'd2}, 1'b0);
    in_valido = 1'b0;
    chk("magic_erro", {31'b0, erro}, 1);
    chk("magic_palavras", {22'b0, palavras}, 0);
    repeat (3) begin @(posedge clock); #1; end
    chk("magic_writes", n_writes, wr0);

    // Range: B=500,N=12 fits exactly; N=13 overflows
    for (int i = 0; i < 12; i++) pl[i] = 32'hA000_0000 + 32'(i);
    run_load(10'd500, 10'd12, 32'h0, 1'b0, -1);
    wait_done(dt);
    chk("range_ok_concluido", {31'b0, concluido}, 1);
    chk("range_ok_palavras", {22'b0, palavras}, 12);
    chk("range_ok_mem511", mem[511], pl[11]);
    wr0 = n_writes;
    pulse_start();
    send_word({6'b111111, 10'd500, 6'b0, 10'd13}, 1'b0);
    in_valido = 1'b0;
    chk("range_bad_erro", {31'b0, erro}, 1);
    chk("range_bad_concluido", {31'b0, concluido}, 0);
    repeat (3) begin @(posedge clock); #1; end
    chk("range_bad_writes", n_writes, wr0);
    chk("range_bad_palavras", {22'b0, palavras}, 0);

    // Checksum mismatch: 1,2,3 with C=7 -> error right after checksum, no verify phase
    pl[0] = 1; pl[1] = 2; pl[2] = 3;
    run_load(10'd40, 10'd3, 32'h1, 1'b0, -1);
    chk("csum_erro", {31'b0, erro}, 1);
    chk("csum_ocupado", {31'b0, ocupado}, 0);
    chk("csum_palavras", {22'b0, palavras}, 3);

    // Readback corruption on one verify read
    for (int i = 0; i < 4; i++) pl[i] = 32'h1234_5678 * 32'(i + 1);
    corrupt_addr = 10'd102;
    corrupt = 1'b1;
    run_load(10'd100, 10'd4, 32'h0, 1'b0, -1);
    wait_done(dt);
    corrupt = 1'b0;
    chk("rdbk_erro", {31'b0, erro}, 1);
    chk("rdbk_concluido", {31'b0, concluido}, 0);
    chk("rdbk_latency", dt, 11);
    chk("rdbk_palavras", {22'b0, palavras}, 4);

    // N=0 with C=0: completes with no memory activity
    wr0 = n_writes;
    end0 = mem_endereco;
    run_load(10'd7, 10'd0, 32'h0, 1'b0, -1);
    wait_done(dt);
    chk("n0_concluido", {31'b0, concluido}, 1);
    chk("n0_writes", n_writes, wr0);
    chk("n0_addr", {22'b0, mem_endereco}, {22'b0, end0});
    chk("n0_palavras", {22'b0, palavras}, 0);

    // Random valid gaps plus ignored start mid-load
    for (int i = 0; i < 8; i++) pl[i] = $urandom;
    run_load(10'd200, 10'd8, 32'h0, 1'b1, 3);
    wait_done(dt);
    chk("gap_concluido", {31'b0, concluido}, 1);
    chk("gap_palavras", {22'b0, palavras}, 8);
    for (int i = 0; i < 8; i++) chk("gap_mem", mem[200 + i], pl[i]);

    // Reset during DADOS: in-flight write dropped, outputs cleared at once
    for (int i = 0; i < 5; i++) pl[i] = 32'hC0DE_0000 + 32'(i);
    pulse_start();
    send_word({6'b111111, 10'd300, 6'b0, 10'd5}, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{a: 10'd300 + 10'(i), d: pl[i]});
      send_word(pl[i], 1'b0);
    end
    send_word(pl[2], 1'b0);
    chk("rst_inflight_write", {31'b0, mem_write}, 1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    in_valido = 1'b0;
    #3;
    reset = 1'b1;
    @(posedge clock); #1;
    run_load(10'd300, 10'd2, 32'h0, 1'b0, -1);
    wait_done(dt);
    chk("restart_concluido", {31'b0, concluido}, 1);
    chk("restart_palavras", {22'b0, palavras}, 2);
    chk("restart_latency", dt, 7);
    chk("restart_mem", mem[301], pl[1]);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
